// File: rtl/periph_timer_sched.sv
// periph_timer_sched: four-channel round-robin timeout scheduler sharing one tick prescaler.
// Define TIMER_SCHED_PERIODIC_EN to reload channels at expiry instead of returning to idle.
module periph_timer_sched #(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 1000,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req_i,
  input  logic [4*CNT_W-1:0] dur_i,
  input  logic [3:0]         abort_i,
  output logic [3:0]         ack_o,
  output logic [3:0]         busy_o,
  output logic [3:0]         done_o,
  output logic               tick_o
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             tick_q, tick_d, found;
  logic [3:0]       ack_q, ack_d, busy_q, busy_d, done_q, done_d, zpend_q, zpend_d, elig;
  logic [1:0]       ptr_q, ptr_d, gidx, idx;
  logic [CNT_W-1:0] gdur;
  logic [CNT_W-1:0] rem_q [4];
  logic [CNT_W-1:0] rem_d [4];
`ifdef TIMER_SCHED_PERIODIC_EN
  logic [CNT_W-1:0] per_q [4];
  logic [CNT_W-1:0] per_d [4];
`endif
  assign tick_d = pcnt_q == PW'(DIV - 1);
  assign pcnt_d = tick_d ? '0 : pcnt_q + 1'b1;
  assign elig   = req_i & ~busy_q & ~abort_i;
  assign gdur   = dur_i[gidx*CNT_W +: CNT_W];
  always_comb begin
    found = 1'b0;
    gidx  = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
  end
  // zero-duration grants never run; their done is deferred one cycle via zpend
  always_comb begin
    busy_d  = busy_q;
    rem_d   = rem_q;
    done_d  = zpend_q;
    zpend_d = '0;
    ack_d   = '0;
    ptr_d   = ptr_q;
`ifdef TIMER_SCHED_PERIODIC_EN
    per_d   = per_q;
`endif
    for (int i = 0; i < 4; i++) begin
      if (busy_q[i] && abort_i[i])
        busy_d[i] = 1'b0;
      else if (busy_q[i] && tick_q && rem_q[i] == CNT_W'(1)) begin
        done_d[i] = 1'b1;
`ifdef TIMER_SCHED_PERIODIC_EN
        rem_d[i] = per_q[i];
`else
        busy_d[i] = 1'b0;
`endif
      end else if (busy_q[i] && tick_q)
        rem_d[i] = rem_q[i] - 1'b1;
    end
    if (found) begin
      ack_d[gidx] = 1'b1;
      ptr_d       = gidx + 2'd1;
      if (gdur == '0)
        zpend_d[gidx] = 1'b1;
      else begin
        busy_d[gidx] = 1'b1;
        rem_d[gidx]  = gdur;
      end
`ifdef TIMER_SCHED_PERIODIC_EN
      per_d[gidx] = gdur;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q  <= '0;
      tick_q  <= 1'b0;
      ack_q   <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      zpend_q <= '0;
      ptr_q   <= '0;
      rem_q   <= '{default: '0};
`ifdef TIMER_SCHED_PERIODIC_EN
      per_q   <= '{default: '0};
`endif
    end else begin
      pcnt_q  <= pcnt_d;
      tick_q  <= tick_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zpend_q <= zpend_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
`ifdef TIMER_SCHED_PERIODIC_EN
      per_q   <= per_d;
`endif
    end
  end
  assign ack_o  = ack_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign tick_o = tick_q;
endmodule

// File: tb/tb_periph_timer_sched.sv
// tb_periph_timer_sched: directed bench for periph_timer_sched with DIV = 5.
// Edge numbers in comments count rising edges after reset release.
module tb_periph_timer_sched;
  localparam int CNT_W = 16;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [3:0]         req = '0;
  logic [3:0]         abort = '0;
  logic [4*CNT_W-1:0] dur = '0;
  logic [3:0]         ack, busy, done;
  logic               tick;
  int                 checks = 0;
  int                 failures = 0;

  periph_timer_sched #(.CLK_HZ(10), .TICK_HZ(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .dur_i(dur), .abort_i(abort),
    .ack_o(ack), .busy_o(busy), .done_o(done), .tick_o(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_dur(input int ch, input int v);
    dur[ch*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  initial begin
    int n;
    logic [3:0] seen;
    cyc(2);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tick", tick, 0);
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      chk("run_tick", tick, (c % 5 == 0) ? 1 : 0);
      chk("run_idle", {ack, busy, done}, 0);
    end
    // zero-duration round robin, edges 21..26
    req = 4'hF;
    for (int j = 0; j < 5; j++) begin
      cyc();
      chk("rr_ack", ack, 1 << (j % 4));
      chk("rr_done", done, (j == 0) ? 0 : 1 << ((j - 1) % 4));
      chk("rr_busy", busy, 0);
    end
    req = '0;
    cyc();
    chk("rr_end_ack", ack, 0);
    chk("rr_end_done", done, 4'b0001);
    // one-shot ch1 dur 3: grant at 27, ticks consumed at 31/36/41
    set_dur(1, 3);
    req = 4'b0010;
    cyc();
    chk("os_ack", ack, 4'b0010);
    chk("os_busy0", busy, 4'b0010);
    req = '0;
    for (n = 1; n <= 20; n++) begin
      cyc();
      if (done != 0) break;
      chk("os_busy", busy, 4'b0010);
    end
    chk("os_lat", n, 14);
    chk("os_done", done, 4'b0010);
    chk("os_busy_fall", busy, 0);
    // ch2 dur 1, abort on its terminal tick at edge 46
    set_dur(2, 1);
    req = 4'b0100;
    cyc();
    chk("ab_ack", ack, 4'b0100);
    chk("ab_busy0", busy, 4'b0100);
    req = '0;
    cyc(3);
    chk("ab_tick", tick, 1);
    chk("ab_busy1", busy, 4'b0100);
    abort = 4'b0100;
    cyc();
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    abort = '0;
    cyc();
    chk("ab_done2", done, 0);
    // reset while ch3 and ch0 run (ptr sits at 3)
    set_dur(0, 5);
    set_dur(3, 5);
    req = 4'b1001;
    cyc();
    chk("rs_ack3", ack, 4'b1000);
    chk("rs_busy3", busy, 4'b1000);
    req = 4'b0001;
    cyc();
    chk("rs_ack0", ack, 4'b0001);
    chk("rs_busy", busy, 4'b1001);
    req = '0;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("rs_busy_now", busy, 0);
    chk("rs_done_now", done, 0);
    chk("rs_ack_now", ack, 0);
    chk("rs_tick_now", tick, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    dur = '0;
    req = 4'b1001;
    cyc();
    chk("rs_next_ack", ack, 4'b0001);
    chk("rs_next_busy", busy, 0);
    chk("rs_next_done", done, 0);
    req = '0;
    cyc();
    chk("rs_zdone", done, 4'b0001);
    chk("rs_zack", ack, 0);
`ifdef TIMER_SCHED_PERIODIC_EN
    // periodic ch0 dur 2: grant at edge 54, expiries at 62, 72
    set_dur(0, 2);
    req = 4'b0001;
    cyc();
    chk("pe_ack", ack, 4'b0001);
    chk("pe_busy0", busy, 4'b0001);
    req = '0;
    for (n = 1; n <= 20; n++) begin
      cyc();
      if (done != 0) break;
    end
    chk("pe_lat", n, 8);
    chk("pe_done", done, 4'b0001);
    chk("pe_busy", busy, 4'b0001);
    for (n = 1; n <= 20; n++) begin
      cyc();
      if (done != 0) break;
      chk("pe_busy_hold", busy, 4'b0001);
    end
    chk("pe_period", n, 10);
    chk("pe_busy2", busy, 4'b0001);
    abort = 4'b0001;
    cyc();
    chk("pe_ab_busy", busy, 0);
    chk("pe_ab_done", done, 0);
    abort = '0;
    seen = '0;
    for (int j = 0; j < 15; j++) begin
      cyc();
      seen |= done | busy;
    end
    chk("pe_quiet", seen, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
